// File: rtl/adventure_grid_fsm.sv
// Grid adventure game: player walks a ROWS x COLS room grid collecting a
// sword, fighting a dragon and seeking treasure under a move budget.
// Ports: clk, reset (async, active-high), n/s/w/e move requests,
//        room, have_sword, dragon_dead, win, dead, moves, bump (all registered).
module adventure_grid_fsm #(
  parameter int COLS          = 4,
  parameter int ROWS          = 3,
  parameter int START_ROOM    = 0,
  parameter int SWORD_ROOM    = 3,
  parameter int DRAGON_ROOM   = 5,
  parameter int TREASURE_ROOM = 11,
  parameter int MAX_MOVES     = 8,
  localparam int CELLS  = ROWS * COLS,
  localparam int IDX_W  = ($clog2(CELLS) > 1) ? $clog2(CELLS) : 1,
  localparam int MOVE_W = ($clog2(MAX_MOVES + 1) > 1) ?
                          $clog2(MAX_MOVES + 1) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n,
  input  logic              s,
  input  logic              w,
  input  logic              e,
  output logic [IDX_W-1:0]  room,
  output logic              have_sword,
  output logic              dragon_dead,
  output logic              win,
  output logic              dead,
  output logic [MOVE_W-1:0] moves,
  output logic              bump
);

  localparam int ROW_W = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = ($clog2(COLS) > 1) ? $clog2(COLS) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROOM / COLS);
  localparam logic [COL_W-1:0] COL_START = COL_W'(START_ROOM % COLS);

  localparam logic [IDX_W-1:0]  IDX_START  = IDX_W'(START_ROOM);
  localparam logic [IDX_W-1:0]  IDX_SWORD  = IDX_W'(SWORD_ROOM);
  localparam logic [IDX_W-1:0]  IDX_DRAGON = IDX_W'(DRAGON_ROOM);
  localparam logic [IDX_W-1:0]  IDX_TREAS  = IDX_W'(TREASURE_ROOM);
  localparam logic [MOVE_W-1:0] MOVE_MAX   = MOVE_W'(MAX_MOVES);

  if (COLS < 2 || ROWS < 2 || MAX_MOVES < 1 ||
      START_ROOM < 0 || START_ROOM >= CELLS ||
      SWORD_ROOM < 0 || SWORD_ROOM >= CELLS ||
      DRAGON_ROOM < 0 || DRAGON_ROOM >= CELLS ||
      TREASURE_ROOM < 0 || TREASURE_ROOM >= CELLS ||
      START_ROOM == SWORD_ROOM || START_ROOM == DRAGON_ROOM ||
      START_ROOM == TREASURE_ROOM || SWORD_ROOM == DRAGON_ROOM ||
      SWORD_ROOM == TREASURE_ROOM || DRAGON_ROOM == TREASURE_ROOM)
  begin : g_param_err
    $error("adventure_grid_fsm: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_WIN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d, tr;
  logic [COL_W-1:0]  col_q, col_d, tc;
  logic [IDX_W-1:0]  troom, room_d;
  logic [MOVE_W-1:0] mv_inc, moves_d;
  logic              req, hit_edge, go, kill;
  logic              sword_d, dd_d, bump_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_PLAY;
      row_q       <= ROW_START;
      col_q       <= COL_START;
      room        <= IDX_START;
      moves       <= '0;
      have_sword  <= 1'b0;
      dragon_dead <= 1'b0;
      win         <= 1'b0;
      dead        <= 1'b0;
      bump        <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      room        <= room_d;
      moves       <= moves_d;
      have_sword  <= sword_d;
      dragon_dead <= dd_d;
      win         <= (state_d == S_WIN);
      dead        <= (state_d == S_DEAD);
      bump        <= bump_d;
    end
  end

  // Next-state: resolve the winning direction and its consequences
  always_comb begin
    req      = n | s | w | e;
    tr       = row_q;
    tc       = col_q;
    hit_edge = 1'b0;
    priority case (1'b1)
      n: if (row_q == '0) hit_edge = 1'b1;
         else tr = row_q - ROW_W'(1);
      s: if (row_q == ROW_LAST) hit_edge = 1'b1;
         else tr = row_q + ROW_W'(1);
      w: if (col_q == '0) hit_edge = 1'b1;
         else tc = col_q - COL_W'(1);
      e: if (col_q == COL_LAST) hit_edge = 1'b1;
         else tc = col_q + COL_W'(1);
      default: ;
    endcase
    go     = (state_q == S_PLAY) && req && !hit_edge;
    troom  = IDX_W'(int'(tr) * COLS + int'(tc));
    mv_inc = moves + MOVE_W'(1);
    // Flags are judged as they stood before this move
    kill   = (troom == IDX_DRAGON) && !have_sword && !dragon_dead;
    state_d = state_q;
    if (go) begin
      if (troom == IDX_TREAS)
        state_d = S_WIN;
      else if (kill || mv_inc == MOVE_MAX)
        state_d = S_DEAD;
    end
  end

  // Output next values
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    room_d  = room;
    moves_d = moves;
    sword_d = have_sword;
    dd_d    = dragon_dead;
    bump_d  = (state_q == S_PLAY) && req && hit_edge;
    if (go) begin
      row_d   = tr;
      col_d   = tc;
      room_d  = troom;
      moves_d = mv_inc;
      if (troom == IDX_SWORD)
        sword_d = 1'b1;
      if (troom == IDX_DRAGON && have_sword)
        dd_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_adventure_grid_fsm.sv
// Self-checking bench for adventure_grid_fsm (default 4x3 grid).
// Vector table plus hand sequences, expectations queued as a scoreboard.
module tb_adventure_grid_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       n, s, w, e;
  logic [3:0] room;
  logic       have_sword, dragon_dead, win, dead;
  logic [3:0] moves;
  logic       bump;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] room;
    logic       sw;
    logic       dd;
    logic       win;
    logic       dead;
    logic [3:0] moves;
    logic       bump;
  } out_t;

  typedef struct {
    bit         rst;
    logic [3:0] dir;
    out_t       exp;
    string      name;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];

  localparam out_t RST = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};

  adventure_grid_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .n          (n),
    .s          (s),
    .w          (w),
    .e          (e),
    .room       (room),
    .have_sword (have_sword),
    .dragon_dead(dragon_dead),
    .win        (win),
    .dead       (dead),
    .moves      (moves),
    .bump       (bump)
  );

  always #5 clk = ~clk;

  function automatic out_t o(int r, bit sw, bit dd, bit wn, bit dn,
                             int m, bit b);
    o = '{4'(r), sw, dd, wn, dn, 4'(m), b};
  endfunction

  task automatic add(bit r, logic [3:0] d, out_t x, string nm);
    vec_t v;
    v.rst = r; v.dir = d; v.exp = x; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic compare(string nm, out_t x);
    out_t a;
    a = {room, have_sword, dragon_dead, win, dead, moves, bump};
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got room=%0d sw=%b dd=%b win=%b dead=%b mv=%0d bump=%b want room=%0d sw=%b dd=%b win=%b dead=%b mv=%0d bump=%b",
               nm, a.room, a.sw, a.dd, a.win, a.dead, a.moves, a.bump,
               x.room, x.sw, x.dd, x.win, x.dead, x.moves, x.bump);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    {n, s, w, e} = 4'b0;
    reset = 1'b1;
    #1 compare("reset", RST);
    #1 reset = 1'b0;
  endtask

  task automatic step(logic [3:0] d, out_t x, string nm);
    out_t q;
    @(negedge clk);
    {n, s, w, e} = d;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      q = sb.pop_front();
      compare(nm, q);
    end
  endtask

  localparam logic [3:0] N = 4'b1000, S = 4'b0100;
  localparam logic [3:0] W = 4'b0010, E = 4'b0001, Z = 4'b0000;

  initial begin
    reset = 1'b1;
    {n, s, w, e} = 4'b0;

    // edge bumps and priority
    add(1, N,      o(0,0,0,0,0,0,1), "t1_n_edge");
    add(0, Z,      o(0,0,0,0,0,0,0), "t1_idle");
    add(0, N|E,    o(0,0,0,0,0,0,1), "t1_ne_prio");
    add(0, Z,      o(0,0,0,0,0,0,0), "t1_idle2");
    add(1, S|W,    o(4,0,0,0,0,1,0), "prio_sw");
    add(0, W|E,    o(4,0,0,0,0,1,1), "prio_we");
    // dragon without sword
    add(1, S,      o(4,0,0,0,0,1,0), "t2_s");
    add(0, E,      o(5,0,0,0,1,2,0), "t2_dragon");
    add(0, E,      o(5,0,0,0,1,2,0), "t2_frozen_e");
    add(0, S,      o(5,0,0,0,1,2,0), "t2_frozen_s");
    // sword, dragon slain, timeout
    add(1, E,      o(1,0,0,0,0,1,0), "t3_e1");
    add(0, E,      o(2,0,0,0,0,2,0), "t3_e2");
    add(0, E,      o(3,1,0,0,0,3,0), "t3_sword");
    add(0, S,      o(7,1,0,0,0,4,0), "t3_s");
    add(0, W,      o(6,1,0,0,0,5,0), "t3_w1");
    add(0, W,      o(5,1,1,0,0,6,0), "t3_slay");
    add(0, E,      o(6,1,1,0,0,7,0), "t3_e");
    add(0, N,      o(2,1,1,0,1,8,0), "t3_timeout");
    add(0, N,      o(2,1,1,0,1,8,0), "t3_frozen");
    // treasure
    add(1, S,      o(4,0,0,0,0,1,0), "t4_s1");
    add(0, S,      o(8,0,0,0,0,2,0), "t4_s2");
    add(0, E,      o(9,0,0,0,0,3,0), "t4_e1");
    add(0, E,      o(10,0,0,0,0,4,0), "t4_e2");
    add(0, E,      o(11,0,0,1,0,5,0), "t4_win");
    add(0, W,      o(11,0,0,1,0,5,0), "t4_frozen");
    // held east
    add(1, E,      o(1,0,0,0,0,1,0), "t5_c1");
    add(0, E,      o(2,0,0,0,0,2,0), "t5_c2");
    add(0, E,      o(3,1,0,0,0,3,0), "t5_c3");
    add(0, E,      o(3,1,0,0,0,3,1), "t5_c4");
    add(0, E,      o(3,1,0,0,0,3,1), "t5_c5");
    add(0, Z,      o(3,1,0,0,0,3,0), "t5_rel");

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].dir, tbl[i].exp, tbl[i].name);
    end

    // async reset mid-game, between clock edges
    do_reset();
    step(S, o(4,0,0,0,0,1,0), "t6_s1");
    step(S, o(8,0,0,0,0,2,0), "t6_s2");
    step(E, o(9,0,0,0,0,3,0), "t6_e");
    {n, s, w, e} = 4'b0;
    reset = 1'b1;
    #1 compare("t6_async_rst", RST);
    @(negedge clk);
    compare("t6_rst_hold", RST);
    reset = 1'b0;
    step(E, o(1,0,0,0,0,1,0), "t6_after");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adventure_grid_fsm.md
Name: adventure_grid_fsm

Overview:
Parametrised successor to the fixed nine-room adventure state machine. It tracks a player on a ROWS x COLS grid of rooms and handles directional moves. It also tracks a collectable sword, a dragon that must be slain with the sword, and a treasure (win) room, plus a move budget that ends the game on timeout. Registered outputs drive the room display and status LEDs in the lab top level.

Parameters:
COLS, 4, grid width in rooms (>=2)
ROWS, 3, grid height in rooms (>=2)
START_ROOM, 0, room index loaded on reset
SWORD_ROOM, 3, room holding the sword
DRAGON_ROOM, 5, room holding the dragon
TREASURE_ROOM, 11, winning room
MAX_MOVES, 8, move budget (>=1)
Constraint: START, SWORD, DRAGON and TREASURE rooms are pairwise distinct and all < ROWS*COLS (checked by elaboration-time assertion).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; returns all state to reset values
n  in  1  move north request (row-1)
s  in  1  move south request (row+1)
w  in  1  move west request (col-1)
e  in  1  move east request (col+1)
room  out  IDX_W  current room index = row*COLS+col; IDX_W = max(1,$clog2(ROWS*COLS))
have_sword  out  1  sword collected
dragon_dead  out  1  dragon slain
win  out  1  game won (sticky)
dead  out  1  game lost by dragon or timeout (sticky)
moves  out  MOVE_W  successful move count; MOVE_W = $clog2(MAX_MOVES+1)
bump  out  1  one-cycle pulse: previous request hit the grid edge

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. On reset: room=START_ROOM, moves=0, all flags=0, bump=0, state=PLAY.
- Outputs: all registered. A request sampled at edge k is visible after edge k (1-cycle latency). No combinational input-to-output paths.
- States: PLAY, WIN, DEAD. WIN and DEAD are terminal; all direction inputs are ignored until reset. room, moves and flags freeze, and bump=0.
- Direction priority when several inputs are high: n > s > w > e. Only the winning direction is evaluated; others are discarded.
- Move (PLAY only): the target is current col/row adjusted by one.
  - Target off-grid (row 0 north, row ROWS-1 south, col 0 west, col COLS-1 east): room unchanged, moves unchanged, bump=1 for exactly one cycle.
  - Target on-grid: room=target, moves+=1, bump=0.
- Held inputs move one room per clock edge. No edge detection.
- Room effects, evaluated on the entered room using flag values from before the move:
  - SWORD_ROOM: have_sword<=1. Stays 1 until reset; re-entry has no effect.
  - DRAGON_ROOM with have_sword=0 and dragon_dead=0: state->DEAD, dead<=1.
  - DRAGON_ROOM with have_sword=1: dragon_dead<=1, play continues; later entries are safe.
  - TREASURE_ROOM: state->WIN, win<=1.
- Timeout: if moves reaches MAX_MOVES on a move that does not enter TREASURE_ROOM, state->DEAD, dead<=1 on that same edge. A win on the final budgeted move takes precedence over timeout. Dragon death and timeout together give DEAD. moves never exceeds MAX_MOVES.
- Edge bumps do not consume budget.
- No inputs active in PLAY: all registers hold, bump=0.
- Reset mid-game: immediate asynchronous return to reset values, independent of clk.
- win and dead are never both 1.

Test Plan:
1. Reset, then n=1 for one cycle -> room=0, moves=0, bump=1 for one cycle then 0. Then n,e asserted together -> n wins, bump=1, room stays 0.
2. From reset: s,e -> room 4 then 5. Sword not held, so dead=1, room=5, moves=2. Further e,s pulses leave room=5, moves=2, bump=0.
3. From reset: e,e,e -> room=3, have_sword=1, moves=3. Then s,w,w -> room=5, dragon_dead=1, dead=0, moves=6. Then e -> room 6, moves=7. Then n -> room 2, moves=8, dead=1 (timeout).
4. From reset: s,s,e,e,e -> rooms 4,8,9,10,11. win=1, moves=5. A subsequent w is ignored, room stays 11.
5. Hold e for 5 cycles from reset -> room 1,2,3 then bump=1 on cycles 4 and 5. moves=3, have_sword=1.
6. Mid-game (room=9, moves=3), assert reset between clock edges -> outputs return to room=0, moves=0, flags=0 before the next rising edge.
